// File: rtl/fifo_read_sequencer.sv
// Read-domain sequencer: drains a first-word-fall-through FIFO in BURST-word bursts onto a valid/ready stream.
// Optional feature macro FIFO_SEQ_FLUSH_EN adds the idle-timeout single-word flush of a below-threshold FIFO.
module fifo_read_sequencer #(
  parameter int WIDTH   = 16,
  parameter int BURST   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] f_dat,
  input  logic             f_empty,
  input  logic             f_almost_empty,
  output logic             f_r_en,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [15:0]      o_burst_cnt
);
  localparam int            RW       = $clog2(BURST + 1);
  localparam logic [RW-1:0] REM_FULL = RW'(BURST);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
`ifdef FIFO_SEQ_FLUSH_EN
    , ST_FLUSH = 2'd3
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          xfer;
  logic          out_free;
  logic          last_rd;
  logic          cnt_inc;

  // The output slot can take a new word when empty or being consumed this cycle.
  assign out_free = !o_valid || i_ready;
  assign o_busy   = (state_q != ST_IDLE);

`ifdef FIFO_SEQ_FLUSH_EN
  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  logic [TW-1:0] timer_q, timer_nxt;
  logic          timer_run, timer_hit;

  assign timer_run = (state_q == ST_IDLE) && i_en && !f_empty && !f_almost_empty;
  assign timer_nxt = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
  assign timer_hit = timer_run && (timer_nxt == TIMER_MAX);
  // A flush is a one-word burst, so it shares the burst read path with rem loaded to 1.
  assign xfer      = (state_q == ST_BURST) || (state_q == ST_FLUSH);

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      timer_q <= '0;
    end else if (timer_run && !timer_hit) begin
      timer_q <= timer_nxt;
    end else begin
      timer_q <= '0;
    end
  end
`else
  assign xfer = (state_q == ST_BURST);
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_d = state_q;
    rem_d   = rem_q;
    f_r_en  = 1'b0;
    last_rd = 1'b0;
    cnt_inc = 1'b0;

    if (xfer && !f_empty && (rem_q != '0) && out_free) begin
      f_r_en = 1'b1;
      rem_d  = rem_q - REM_ONE;
      if (rem_q == REM_ONE) begin
        last_rd = 1'b1;
        state_d = ST_DRAIN;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_en && f_almost_empty) begin
          state_d = ST_BURST;
          rem_d   = REM_FULL;
        end
`ifdef FIFO_SEQ_FLUSH_EN
        else if (timer_hit) begin
          state_d = ST_FLUSH;
          rem_d   = REM_ONE;
        end
`endif
      end
      ST_DRAIN: begin
        if (out_free) begin
          cnt_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (r_rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      o_burst_cnt <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (cnt_inc) o_burst_cnt <= o_burst_cnt + 16'd1;
    end
  end

  // A stalled word (o_valid && !i_ready) keeps data, valid and last untouched.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      o_dat   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (f_r_en) begin
      o_dat   <= f_dat;
      o_valid <= 1'b1;
      o_last  <= last_rd;
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_sequencer.sv
// Bench for fifo_read_sequencer: queue-based FIFO and scoreboard model, directed cases plus random traffic.
// Build with FIFO_SEQ_FLUSH_EN defined to exercise the timeout flush instead of the no-flush hold.
module tb_fifo_read_sequencer;
  localparam int WIDTH   = 16;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 64;

  logic             r_clk = 1'b0;
  logic             r_rst = 1'b1;
  logic             i_en = 1'b0;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] f_dat = '0;
  logic             f_empty = 1'b1;
  logic             f_almost_empty = 1'b0;
  logic             f_r_en;
  logic [WIDTH-1:0] o_dat;
  logic             o_valid;
  logic             o_last;
  logic             o_busy;
  logic [15:0]      o_burst_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  bit          last_q[$];
  int          xfer_left = 0;
  logic [15:0] exp_cnt = '0;
  int          rd_count = 0;
  bit          rd_req = 1'b0;
  bit          hold_prev = 1'b0;
  logic [15:0] prev_dat = '0;
  bit          prev_last = 1'b0;

  fifo_read_sequencer #(.WIDTH(WIDTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .r_clk          (r_clk),
    .r_rst          (r_rst),
    .i_en           (i_en),
    .f_dat          (f_dat),
    .f_empty        (f_empty),
    .f_almost_empty (f_almost_empty),
    .f_r_en         (f_r_en),
    .o_dat          (o_dat),
    .o_valid        (o_valid),
    .o_last         (o_last),
    .i_ready        (i_ready),
    .o_busy         (o_busy),
    .o_burst_cnt    (o_burst_cnt)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void update_pins();
    f_empty        = (fifo_q.size() == 0);
    f_almost_empty = (fifo_q.size() >= BURST);
    f_dat          = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_pins();
  endtask

  // FIFO model: a read seen before the edge pops the head just after it.
  always @(posedge r_clk) begin
    #1;
    if (rd_req && fifo_q.size() != 0) void'(fifo_q.pop_front());
    update_pins();
  end

  // Compare process: transfer framing model plus protocol rules, sampled mid-cycle.
  always @(negedge r_clk) begin
    if (r_rst) begin
      exp_q     = fifo_q;
      last_q.delete();
      xfer_left = 0;
      exp_cnt   = '0;
      hold_prev = 1'b0;
      rd_req    = 1'b0;
    end else begin
      check("burst_cnt", o_burst_cnt, exp_cnt);
      check("last_without_valid", o_last & ~o_valid, 0);
      if (hold_prev) begin
        check("stall_valid", o_valid, 1);
        check("stall_dat", o_dat, prev_dat);
        check("stall_last", o_last, prev_last);
      end
      if (f_r_en) begin
        check("read_while_empty", f_empty, 0);
        check("read_while_stalled", o_valid && !i_ready, 0);
        if (xfer_left == 0) begin
`ifdef FIFO_SEQ_FLUSH_EN
          xfer_left = (fifo_q.size() >= BURST) ? BURST : 1;
`else
          xfer_left = BURST;
`endif
        end
        xfer_left--;
        last_q.push_back(xfer_left == 0);
        rd_count++;
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0 || last_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got 0x%0h, no word expected (t=%0t)", o_dat, $time);
        end else begin
          check("data", o_dat, exp_q[0]);
          check("last", o_last, last_q[0]);
          if (last_q[0]) exp_cnt++;
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
        end
      end
      hold_prev = o_valid && !i_ready;
      prev_dat  = o_dat;
      prev_last = o_last;
      rd_req    = f_r_en;
    end
  end

  task automatic wait_cnt(input string name, input logic [15:0] target, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge r_clk); #2;
      if (o_burst_cnt == target) break;
    end
    check(name, o_burst_cnt, target);
  endtask

  task automatic do_reset();
    @(posedge r_clk); #2;
    r_rst = 1'b1;
    @(posedge r_clk); #2;
    r_rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int idle;
    bit found;
    update_pins();

    // Reset state
    @(negedge r_clk);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_dat", o_dat, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cnt", o_burst_cnt, 0);
    check("rst_rd_en", f_r_en, 0);
    @(posedge r_clk); #2;
    r_rst = 1'b0; i_en = 1'b1; i_ready = 1'b1;

    // One full burst with the sink always ready: pinned cycle by cycle
    @(posedge r_clk); #2;
    for (int k = 1; k <= 8; k++) push_word(16'(k));
    @(negedge r_clk);
    check("t1_no_read_yet", f_r_en, 0);
    check("t1_idle", o_busy, 0);
    @(negedge r_clk);
    check("t1_first_read", f_r_en, 1);
    check("t1_busy", o_busy, 1);
    check("t1_not_valid_yet", o_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge r_clk);
      check("t1_valid", o_valid, 1);
      check("t1_dat", o_dat, k);
      check("t1_last", o_last, (k == 8));
    end
    @(negedge r_clk);
    check("t1_done_valid", o_valid, 0);
    check("t1_done_cnt", o_burst_cnt, 1);
    check("t1_done_busy", o_busy, 0);

    // Sink ready toggling every cycle
    @(posedge r_clk); #2;
    for (int k = 1; k <= 8; k++) push_word(16'(16'h0010 + k));
    for (int c = 0; c < 100; c++) begin
      @(posedge r_clk); #2;
      if (o_burst_cnt == 16'd2) break;
      i_ready = ~i_ready;
    end
    check("t2_cnt", o_burst_cnt, 2);
    check("t2_all_out", exp_q.size(), 0);
    i_ready = 1'b1;

    // Reset while word 4 of a burst is on the output
    @(posedge r_clk); #2;
    for (int k = 1; k <= 8; k++) push_word(16'(16'h0020 + k));
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge r_clk); #2;
      if (o_valid && o_dat == 16'h0024) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_word4_seen", found, 1);
    r_rst = 1'b1;
    #1;
    check("t3_rst_rd_en", f_r_en, 0);
    check("t3_rst_valid", o_valid, 0);
    check("t3_rst_last", o_last, 0);
    check("t3_rst_dat", o_dat, 0);
    check("t3_rst_busy", o_busy, 0);
    check("t3_rst_cnt", o_burst_cnt, 0);
    check("t3_fifo_left", fifo_q.size(), 4);
    @(posedge r_clk); #2;
    r_rst = 1'b0;
    for (int k = 9; k <= 12; k++) push_word(16'(16'h0020 + k));
    wait_cnt("t3_next_burst", 16'd1, 60);
    check("t3_all_out", exp_q.size(), 0);

    // Enable low holds 16 queued words; raising it gives two bursts
    do_reset();
    i_en = 1'b0;
    @(posedge r_clk); #2;
    for (int k = 1; k <= 16; k++) push_word(16'(16'h0030 + k));
    r0 = rd_count;
    repeat (30) @(posedge r_clk);
    #2;
    check("t4_no_read", rd_count - r0, 0);
    check("t4_idle", o_busy, 0);
    i_en = 1'b1;
    wait_cnt("t4_two_bursts", 16'd2, 80);
    check("t4_fifo_empty", fifo_q.size(), 0);

    // Random traffic in whole bursts against the scoreboard
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge r_clk); #2;
      i_ready = ($urandom_range(9) < 7);
      if ($urandom_range(39) == 0) i_en = ~i_en;
      if ($urandom_range(11) == 0 && fifo_q.size() < 48)
        for (int k = 0; k < 8; k++) push_word(16'($urandom));
    end
    i_en = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge r_clk); #2;
      if (fifo_q.size() < BURST && !o_busy && !o_valid) break;
    end
    check("rand_fifo_drained", fifo_q.size(), 0);
    check("rand_all_out", exp_q.size(), 0);

    // Three words left below the threshold
    do_reset();
    @(posedge r_clk); #2;
    push_word(16'h00A1);
    push_word(16'h00A2);
    push_word(16'h00A3);
`ifdef FIFO_SEQ_FLUSH_EN
    idle = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge r_clk);
      if (f_r_en) break;
      idle++;
    end
    check("t5_idle_before_flush", idle, TIMEOUT);
    wait_cnt("t5_three_flushes", 16'd3, 400);
    check("t5_fifo_empty", fifo_q.size(), 0);
    check("t5_all_out", exp_q.size(), 0);
`else
    r0 = rd_count;
    repeat (1000) @(posedge r_clk);
    #2;
    check("t5_no_read", rd_count - r0, 0);
    check("t5_idle", o_busy, 0);
    check("t5_words_kept", fifo_q.size(), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_read_sequencer.md
# fifo_read_sequencer

Read-domain controller that drains the asynchronous FIFO in fixed-length bursts and presents samples to the FIR filter over a valid/ready stream. It issues the FIFO read enable, registers the read data, marks burst boundaries, and optionally flushes a partial burst after an idle timeout. It sits between the FIFO read port and the FIR input, clocked entirely in the read domain.

## Interface
- WIDTH, 16, sample width; matches FIFO WIDTH.
- BURST, 8, words per full burst; FIFO ALMOST_EMPTY must be ≥ BURST.
- TIMEOUT, 64, idle cycles with a non-empty FIFO before a partial flush.
- r_clk  in  1  read-domain clock.
- r_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  allows new bursts to start; a burst in progress always completes.
- f_dat  in  WIDTH  FIFO read data (first-word-fall-through).
- f_empty  in  1  FIFO empty flag.
- f_almost_empty  in  1  FIFO threshold flag: high when the FIFO holds ≥ ALMOST_EMPTY words.
- f_r_en  out  1  FIFO read enable (combinational).
- o_dat  out  WIDTH  sample to FIR (registered).
- o_valid  out  1  o_dat valid.
- o_last  out  1  final word of the current burst or flush.
- i_ready  in  1  FIR accepts o_dat when o_valid && i_ready.
- o_busy  out  1  state ≠ IDLE.
- o_burst_cnt  out  16  completed bursts and flushes; wraps at 2^16.

## Operation
- States: IDLE, BURST, FLUSH, DRAIN.
- IDLE: the timer counts cycles while i_en && !f_empty && !f_almost_empty. It clears otherwise.
  - i_en && f_almost_empty → BURST; load rem = BURST.
  - Timer reaches TIMEOUT → FLUSH; clear the timer.
- BURST: f_r_en = !f_empty && rem ≠ 0 && (!o_valid || i_ready). Each f_r_en decrements rem.
  - f_empty mid-burst stalls reads; the state is held.
  - The read with rem == 1 sets o_last with that word. Then go to DRAIN.
- FLUSH: same read rule, without rem.
  - The read that sees the FIFO holding its last word sets o_last: f_r_en && next f_empty is unknown, so o_last marks the read taken when rem-free count equals the words sampled available. Implement this as the flush length latched on FLUSH entry, equal to 1 (one word per flush). Then go to DRAIN.
- DRAIN: wait until !o_valid || i_ready, i.e. the last word is accepted. Then increment o_burst_cnt → IDLE.
- Output register:
  - On f_r_en: o_dat ← f_dat, o_valid ← 1.
  - Else if i_ready: o_valid ← 0.
- Width rules: rem is $clog2(BURST+1) bits; the timer is $clog2(TIMEOUT+1) bits and saturates.
- Reset (asynchronous, any state): IDLE, o_valid=0, o_last=0, o_dat=0, o_busy=0, o_burst_cnt=0, rem=0, timer=0, f_r_en=0.

## Timing
- f_almost_empty seen high at edge N (IDLE):
  - BURST from N+1.
  - f_r_en high during cycle N+1.
  - First o_valid at N+2.
- With i_ready held high: one word per cycle; BURST words in BURST consecutive cycles.
- o_last is high only while the last word is valid.
- IDLE is re-entered 1 cycle after the last word is accepted. The next burst may start on the following edge.
- i_ready low holds o_dat, o_valid and o_last stable and blocks f_r_en.
- i_en falling mid-burst: no effect until IDLE.

## Configuration
- Macro `FIFO_SEQ_FLUSH_EN`.
- Defined: FLUSH state and timeout timer present. A FIFO left below the threshold for TIMEOUT cycles is drained one word per flush, with o_last set on each flushed word.
- Undefined: the timer and FLUSH are removed. Only full BURST-length transfers occur, and words below the threshold remain in the FIFO indefinitely.

## Test plan
- BURST=8, FIFO preloaded with 8 words 0x0001..0x0008, i_ready=1:
  - o_dat 0x0001..0x0008 on 8 consecutive cycles.
  - o_last only on 0x0008.
  - o_burst_cnt=1.
- Same stimulus, i_ready toggled 1/0 each cycle: all 8 words delivered in order, no duplicates or drops, and f_r_en never high while o_valid && !i_ready.
- 3 words loaded, flush enabled, TIMEOUT=64: no read for 64 cycles; then 3 single-word flushes with o_last each, and o_burst_cnt=3.
- Same 3 words with flush disabled: f_r_en stays 0 for 1000 cycles.
- r_rst asserted at word 4 of a burst: all outputs 0 and IDLE within the same cycle; the next burst starts cleanly when f_almost_empty is high.
- i_en=0 with 16 words queued: no reads. Raise i_en: two back-to-back bursts of 8, and o_burst_cnt=2.
